// File: rtl/hls_activity_monitor_pkg.sv
// Shared types, register indices and saturating increment for the activity monitor.
// The optional ACTMON_MINMAX_EN build adds min/max latency tracking.
package actmon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] REG_INV    = 3'd0;
  localparam logic [2:0] REG_BUSY   = 3'd1;
  localparam logic [2:0] REG_STALL  = 3'd2;
  localparam logic [2:0] REG_ITER   = 3'd3;
  localparam logic [2:0] REG_LAST   = 3'd4;
  localparam logic [2:0] REG_MIN    = 3'd5;
  localparam logic [2:0] REG_MAX    = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] m
  );
    return (v >= m) ? m : v + 64'd1;
  endfunction

endpackage

// File: rtl/hls_activity_monitor_if.sv
// ap_ctrl handshake bundle for NUM_CH monitored HLS blocks.
// master drives the handshake, slave is the monitor.
interface hls_activity_monitor_if #(
  parameter int NUM_CH = 5
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic [NUM_CH-1:0] iter_end;

  modport master (
    output ap_start, ap_ready, ap_done,
    output ap_continue, iter_end
  );

  modport slave (
    input ap_start, ap_ready, ap_done,
    input ap_continue, iter_end
  );
endinterface

// File: rtl/hls_activity_monitor_channel.sv
// One channel: ap_ctrl FSM, latency counter and saturating statistics.
// min/max latency registers exist only when ACTMON_MINMAX_EN is defined.
module actmon_channel
  import actmon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             ready_i,
  input  logic             done_i,
  input  logic             cont_i,
  input  logic             iter_i,
  input  logic [2:0]       rd_reg_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             ovf_o
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MAXV = '1;
  localparam cnt_t ONE  = cnt_t'(1);

  function automatic cnt_t inc(input cnt_t v);
    return cnt_t'(sat_inc(64'(v), 64'(MAXV)));
  endfunction

  state_e state_q, state_d;
  cnt_t   lat_q, lat_d, lat_cur, lat_com;
  cnt_t   inv_q, inv_d, busy_q, busy_d;
  cnt_t   stall_q, stall_d, iter_q, iter_d;
  cnt_t   last_q, last_d, min_rd, max_rd;
  logic   ovf_q, ovf_d, seen_q, seen_d;
  logic   acc, commit, busy_inc, stall_inc, hit;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    acc     = 1'b0;
    commit  = 1'b0;
    lat_cur = inc(lat_q);
    lat_com = lat_cur;
    unique case (state_q)
      IDLE: if (start_i) begin
        acc     = 1'b1;
        lat_d   = ONE;
        lat_com = ONE;
        state_d = BUSY;
        if (done_i) begin
          commit  = 1'b1;
          state_d = cont_i ? IDLE : DONE_WAIT;
        end
      end
      BUSY: begin
        lat_d = lat_cur;
        if (done_i) begin
          commit = 1'b1;
          if (!cont_i) begin
            state_d = DONE_WAIT;
          end else if (start_i) begin
            acc   = 1'b1;
            lat_d = ONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE_WAIT: if (cont_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The start-accept cycle already belongs to the invocation.
  assign busy_inc  = (state_q == BUSY) |
                     ((state_q == IDLE) & start_i);
  assign stall_inc = (state_q == DONE_WAIT);
  assign hit = (acc & (inv_q == MAXV)) |
               (busy_inc & (busy_q == MAXV)) |
               (stall_inc & (stall_q == MAXV)) |
               (iter_i & (iter_q == MAXV));

  always_comb begin
    inv_d   = inv_q;
    busy_d  = busy_q;
    stall_d = stall_q;
    iter_d  = iter_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    seen_d  = seen_q | ready_i;
    if (clr_i) begin
      inv_d   = '0;
      busy_d  = '0;
      stall_d = '0;
      iter_d  = '0;
      last_d  = '0;
      ovf_d   = 1'b0;
    end else if (en_i) begin
      if (acc)       inv_d   = inc(inv_q);
      if (busy_inc)  busy_d  = inc(busy_q);
      if (stall_inc) stall_d = inc(stall_q);
      if (iter_i)    iter_d  = inc(iter_q);
      if (commit)    last_d  = lat_com;
      ovf_d = ovf_q | hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lat_q   <= '0;
      inv_q   <= '0;
      busy_q  <= '0;
      stall_q <= '0;
      iter_q  <= '0;
      last_q  <= '0;
      ovf_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
      iter_q  <= iter_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      seen_q  <= seen_d;
    end
  end

`ifdef ACTMON_MINMAX_EN
  cnt_t min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clr_i) begin
      min_d = '1;
      max_d = '0;
    end else if (en_i && commit) begin
      if (lat_com < min_q) min_d = lat_com;
      if (lat_com > max_q) max_d = lat_com;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_rd = min_q;
  assign max_rd = max_q;
`else
  assign min_rd = '0;
  assign max_rd = '0;
`endif

  always_comb begin
    rd_data_o = '0;
    unique case (rd_reg_i)
      REG_INV:    rd_data_o = inv_q;
      REG_BUSY:   rd_data_o = busy_q;
      REG_STALL:  rd_data_o = stall_q;
      REG_ITER:   rd_data_o = iter_q;
      REG_LAST:   rd_data_o = last_q;
      REG_MIN:    rd_data_o = min_rd;
      REG_MAX:    rd_data_o = max_rd;
      REG_STATUS: rd_data_o = cnt_t'({seen_q, ovf_q, state_q});
      default:    rd_data_o = '0;
    endcase
  end

  assign ovf_o = ovf_q;

endmodule

// File: rtl/hls_activity_monitor.sv
// Per-channel ap_ctrl activity monitor with a registered read port.
// Define ACTMON_MINMAX_EN to track min/max latency (regs 5/6).
module hls_activity_monitor
  import actmon_pkg::*;
#(
  parameter  int NUM_CH = 5,
  parameter  int CNT_W  = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  hls_activity_monitor_if.slave  ap,
  input  logic [CH_W-1:0]        rd_ch,
  input  logic [2:0]             rd_reg,
  output logic [CNT_W-1:0]       rd_data,
  output logic [NUM_CH-1:0]      ovf
);

  localparam int SLOTS = 2 ** CH_W;

  logic [CNT_W-1:0] ch_data [SLOTS];
  logic [CNT_W-1:0] rd_data_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    actmon_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_i     (clock),
      .rst_ni    (reset),
      .en_i      (en),
      .clr_i     (clr),
      .start_i   (ap.ap_start[i]),
      .ready_i   (ap.ap_ready[i]),
      .done_i    (ap.ap_done[i]),
      .cont_i    (ap.ap_continue[i]),
      .iter_i    (ap.iter_end[i]),
      .rd_reg_i  (rd_reg),
      .rd_data_o (ch_data[i]),
      .ovf_o     (ovf[i])
    );
  end

  // Unpopulated select codes read as zero.
  for (genvar i = NUM_CH; i < SLOTS; i++) begin : g_pad
    assign ch_data[i] = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= ch_data[rd_ch];
  end

  assign rd_data = rd_data_q;

endmodule
